// File: rtl/fbp_sched_pkg.sv
// Shared types and status-word layout for the FBP job scheduler.
// The status word carries sticky error bits, FIFO occupancy and a wrapping job counter.
package fbp_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SET_ANGLE = 3'd1,
    ST_SET_IMG   = 3'd2,
    ST_START     = 3'd3,
    ST_WAIT_ACK  = 3'd4,
    ST_RUN       = 3'd5,
    ST_DONE      = 3'd6,
    ST_ABORT     = 3'd7
  } sched_state_e;

  localparam int STAT_BUSY      = 0;
  localparam int STAT_FULL      = 1;
  localparam int STAT_EMPTY     = 2;
  localparam int STAT_OVF       = 3;
  localparam int STAT_ACK_TO    = 4;
  localparam int STAT_RUN_TO    = 5;
  localparam int STAT_LEVEL_LSB = 6;
  localparam int STAT_LEVEL_MSB = 8;
  localparam int STAT_JOBS_LSB  = 16;
  localparam int STAT_JOBS_MSB  = 23;

  // A set in the same cycle as a clear must survive.
  function automatic logic sticky_next(input logic set, input logic clr, input logic q);
    return set | (q & ~clr);
  endfunction

endpackage

// File: rtl/fbp_job_scheduler_if.sv
// Accelerator-facing bundle: two address handshakes, start/finish, and soft reset.
interface fbp_job_scheduler_if #(
  parameter int AW = 32
);
  logic          angle_data_base_addr_valid;
  logic          angle_data_base_addr_ready;
  logic [AW-1:0] angle_data_base_addr;
  logic          img_base_addr_valid;
  logic          img_base_addr_ready;
  logic [AW-1:0] img_base_addr;
  logic          start_fbp;
  logic          finsh_fbp;
  logic          soft_rstn;

  modport master (
    output angle_data_base_addr_valid, angle_data_base_addr,
    output img_base_addr_valid, img_base_addr,
    output start_fbp, soft_rstn,
    input  angle_data_base_addr_ready, img_base_addr_ready, finsh_fbp
  );

  modport slave (
    input  angle_data_base_addr_valid, angle_data_base_addr,
    input  img_base_addr_valid, img_base_addr,
    input  start_fbp, soft_rstn,
    output angle_data_base_addr_ready, img_base_addr_ready, finsh_fbp
  );
endinterface

// File: rtl/fbp_job_fifo.sv
// Synchronous job FIFO with flush; a push into a full FIFO is accepted only when a pop
// happens in the same cycle. DEPTH must be a power of two so the pointers wrap naturally.
module fbp_job_fifo #(
  parameter  int WIDTH = 64,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == LW'(DEPTH));
  assign empty   = (count_q == '0);
  assign level   = count_q;
  assign rd_data = mem[rd_ptr_q];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // NOTE: every variable gets a default at the top of an always_comb so no path can infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + LW'(do_push) - LW'(do_pop);
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/fbp_job_scheduler.sv
// Dispatches queued FBP jobs to the accelerator one at a time, supervising each run
// with ack/run watchdogs and recovering through a timed soft-reset pulse.
module fbp_job_scheduler
  import fbp_sched_pkg::*;
#(
  parameter int          C_S_AXI_DATA_WIDTH = 32,
  parameter int          JOB_DEPTH          = 4,
  parameter int          ACK_TIMEOUT        = 256,
  parameter logic [31:0] RUN_TIMEOUT        = 32'h00FF_FFFF,
  parameter int          SRST_CYCLES        = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic                          job_push,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] job_angle_addr,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] job_img_addr,
  input  logic                          abort_req,
  input  logic                          err_clr,
  fbp_job_scheduler_if.master           acc,
  output logic                          job_done,
  output logic [C_S_AXI_DATA_WIDTH-1:0] run_cycles,
  output logic [C_S_AXI_DATA_WIDTH-1:0] status
);

  localparam int DW    = C_S_AXI_DATA_WIDTH;
  localparam int LVL_W = $clog2(JOB_DEPTH) + 1;

  sched_state_e  state_q, state_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] angle_addr_q, angle_addr_d;
  logic [DW-1:0] img_addr_q, img_addr_d;
  logic [DW-1:0] run_cycles_q, run_cycles_d;
  logic [7:0]    jobs_done_q, jobs_done_d;
  logic          ovf_q, ovf_d;
  logic          ack_to_q, ack_to_d;
  logic          run_to_q, run_to_d;
  logic          ack_to_set, run_to_set, ovf_set;

  logic              fifo_push, fifo_pop, fifo_flush;
  logic              fifo_full, fifo_empty;
  logic [LVL_W-1:0]  fifo_level;
  logic [2*DW-1:0]   fifo_head;

  // An abort strobe always swallows a same-cycle push, so that push never counts as overflow.
  assign fifo_push = job_push & ~abort_req;
  assign ovf_set   = fifo_push & fifo_full & ~fifo_pop;

  fbp_job_fifo #(
    .WIDTH (2 * DW),
    .DEPTH (JOB_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (fifo_push),
    .wr_data ({job_angle_addr, job_img_addr}),
    .pop     (fifo_pop),
    .flush   (fifo_flush),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      angle_addr_q <= '0;
      img_addr_q   <= '0;
      run_cycles_q <= '0;
      jobs_done_q  <= '0;
      ovf_q        <= 1'b0;
      ack_to_q     <= 1'b0;
      run_to_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      angle_addr_q <= angle_addr_d;
      img_addr_q   <= img_addr_d;
      run_cycles_q <= run_cycles_d;
      jobs_done_q  <= jobs_done_d;
      ovf_q        <= ovf_d;
      ack_to_q     <= ack_to_d;
      run_to_q     <= run_to_d;
    end
  end

  // The one counter serves as ack watchdog, run-length counter and soft-reset timer.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    angle_addr_d = angle_addr_q;
    img_addr_d   = img_addr_q;
    run_cycles_d = run_cycles_q;
    jobs_done_d  = jobs_done_q;
    fifo_pop     = 1'b0;
    fifo_flush   = 1'b0;
    ack_to_set   = 1'b0;
    run_to_set   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (abort_req) begin
          fifo_flush = 1'b1;
        end else if (enable && !fifo_empty && acc.finsh_fbp) begin
          fifo_pop     = 1'b1;
          angle_addr_d = fifo_head[2*DW-1:DW];
          img_addr_d   = fifo_head[DW-1:0];
          state_d      = ST_SET_ANGLE;
        end
      end
      ST_SET_ANGLE: if (acc.angle_data_base_addr_ready) state_d = ST_SET_IMG;
      ST_SET_IMG:   if (acc.img_base_addr_ready)        state_d = ST_START;
      ST_START: begin
        cnt_d   = '0;
        state_d = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (!acc.finsh_fbp) begin
          cnt_d   = '0;
          state_d = ST_RUN;
        end else if (cnt_q == DW'(ACK_TIMEOUT - 1)) begin
          ack_to_set = 1'b1;
          cnt_d      = '0;
          state_d    = ST_ABORT;
        end else begin
          cnt_d = cnt_q + DW'(1);
        end
      end
      ST_RUN: begin
        if (acc.finsh_fbp) begin
          state_d = ST_DONE;
        end else if (cnt_q == DW'(RUN_TIMEOUT - 32'd1)) begin
          run_to_set = 1'b1;
          cnt_d      = '0;
          state_d    = ST_ABORT;
        end else begin
          cnt_d = cnt_q + DW'(1);
        end
      end
      ST_DONE: begin
        run_cycles_d = cnt_q + DW'(1);
        jobs_done_d  = jobs_done_q + 8'd1;
        state_d      = ST_IDLE;
      end
      ST_ABORT: begin
        if (cnt_q == DW'(SRST_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + DW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A host abort pre-empts any in-flight step, including a watchdog firing this cycle.
    if (abort_req && state_q != ST_IDLE && state_q != ST_ABORT) begin
      fifo_flush = 1'b1;
      ack_to_set = 1'b0;
      run_to_set = 1'b0;
      cnt_d      = '0;
      state_d    = ST_ABORT;
    end

    ovf_d    = sticky_next(ovf_set,    err_clr, ovf_q);
    ack_to_d = sticky_next(ack_to_set, err_clr, ack_to_q);
    run_to_d = sticky_next(run_to_set, err_clr, run_to_q);
  end

  // Outputs decode only registered state, so ABORT and reset force every strobe low.
  always_comb begin
    acc.angle_data_base_addr_valid = (state_q == ST_SET_ANGLE);
    acc.img_base_addr_valid        = (state_q == ST_SET_IMG);
    acc.start_fbp                  = (state_q == ST_START);
    acc.soft_rstn                  = (state_q != ST_ABORT);
    acc.angle_data_base_addr       = angle_addr_q;
    acc.img_base_addr              = img_addr_q;
    job_done                       = (state_q == ST_DONE);
    run_cycles                     = run_cycles_q;

    status                                = '0;
    status[STAT_BUSY]                     = (state_q != ST_IDLE);
    status[STAT_FULL]                     = fifo_full;
    status[STAT_EMPTY]                    = fifo_empty;
    status[STAT_OVF]                      = ovf_q;
    status[STAT_ACK_TO]                   = ack_to_q;
    status[STAT_RUN_TO]                   = run_to_q;
    status[STAT_LEVEL_MSB:STAT_LEVEL_LSB] = 3'(fifo_level);
    status[STAT_JOBS_MSB:STAT_JOBS_LSB]   = jobs_done_q;
  end

endmodule
